bch_decode_sched: RTL and testbench

- Controller that sequences codewords through the shared decode chain: syndrome unit, then sigma/key solver, then error locator.
- Generates all start/ce strobes between the stages and limits in-flight codewords to DEPTH.
- Carries a per-codeword tag and the solver err_count alongside each codeword, so locator output is labelled.
- Provides a flush/drain sequence for mode changes.

---
 rtl/bch_decode_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_bch_decode_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bch_decode_sched.sv
// bch_decode_sched: sequences codewords through syndrome -> key solver ->
// locator, generates the inter-stage strobes, limits codewords in flight to
// DEPTH and labels locator output with the codeword's tag and err_count.
// Optional statistics counters are built when BCH_SCHED_STATS_EN is defined.
module bch_decode_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    output logic             syn_start,
    output logic             syn_ce,
    input  logic             syn_ready,
    input  logic             syn_done,
    output logic             key_start,
    input  logic             key_ready,
    input  logic             key_done,
    output logic             key_ack,
    input  logic [ERR_W-1:0] err_count,
    output logic             loc_start,
    input  logic             loc_ready,
    input  logic             loc_valid,
    input  logic             loc_first,
    input  logic             loc_last,
    output logic [TAG_W-1:0] out_tag,
    output logic [ERR_W-1:0] out_err_count,
    output logic             out_valid,
    input  logic             flush,
    output logic             flush_done,
    output logic             overflow,
    output logic [15:0]      stat_cw,
    output logic [15:0]      stat_err_cw
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   cnt_fill_q, cnt_fill_d;
    logic [PTR_W-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PTR_W-1:0]   cnt_wr_q, cnt_wr_d, cnt_rd_q, cnt_rd_d;
    logic [TAG_W-1:0]   tag_mem_q [DEPTH];
    logic [TAG_W-1:0]   tag_mem_d [DEPTH];
    logic [ERR_W-1:0]   cnt_mem_q [DEPTH];
    logic [ERR_W-1:0]   cnt_mem_d [DEPTH];
    logic               overflow_q, overflow_d;

    logic tag_empty, cnt_empty, cnt_full;
    logic pop_req, pop_ok, cnt_push, cnt_pop;

    // The locator's first-beat flag carries no information the scheduler
    // needs: the tag is held from push until the last beat pops it.
    logic unused_loc_first;
    assign unused_loc_first = loc_first;

    // Inter-stage strobes and FIFO handshake decode, all combinational.
    always_comb begin
        tag_empty = (inflight_q == '0);
        cnt_empty = (cnt_fill_q == '0);
        cnt_full  = (cnt_fill_q == DEPTH_C);

        syn_ce    = !syn_done || key_ready;
        key_start = syn_done && key_ready;
        key_ack   = key_done && loc_ready;
        loc_start = key_done && loc_ready;

        in_ready  = (state_q == ST_RUN) && (inflight_q < DEPTH_C);
        syn_start = in_valid && in_first && syn_ready && syn_ce && in_ready;

        // A pop against an empty FIFO is flagged but never moves pointers.
        pop_req   = loc_valid && loc_last;
        pop_ok    = pop_req && !tag_empty;
        cnt_pop   = pop_ok && !cnt_empty;
        cnt_push  = loc_start && !cnt_full;

        out_valid     = loc_valid && !tag_empty;
        out_tag       = tag_empty ? '0 : tag_mem_q[tag_rd_q];
        out_err_count = cnt_empty ? '0 : cnt_mem_q[cnt_rd_q];
        overflow      = overflow_q;
        flush_done    = (state_q == ST_DONE);
    end

    // Next-state for both FIFOs, in-flight count and the sticky error flag.
    always_comb begin
        tag_mem_d = tag_mem_q;
        cnt_mem_d = cnt_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        cnt_wr_d  = cnt_wr_q;
        cnt_rd_d  = cnt_rd_q;

        if (syn_start) begin
            tag_mem_d[tag_wr_q] = in_tag;
            tag_wr_d            = tag_wr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
        end
        if (cnt_push) begin
            cnt_mem_d[cnt_wr_q] = err_count;
            cnt_wr_d            = cnt_wr_q + PTR_W'(1);
        end
        if (cnt_pop) begin
            cnt_rd_d = cnt_rd_q + PTR_W'(1);
        end

        inflight_d = inflight_q;
        case ({syn_start, pop_ok})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        cnt_fill_d = cnt_fill_q;
        case ({cnt_push, cnt_pop})
            2'b10:   cnt_fill_d = cnt_fill_q + CNT_W'(1);
            2'b01:   cnt_fill_d = cnt_fill_q - CNT_W'(1);
            default: cnt_fill_d = cnt_fill_q;
        endcase

        overflow_d = overflow_q
                   | (pop_req && tag_empty)
                   | (loc_valid && tag_empty)
                   | (loc_start && cnt_full);
    end

    // Flush/drain sequencing: stop accepting, wait for the pipeline to empty,
    // then pulse flush_done for one cycle and resume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (tag_empty && !pop_ok) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            inflight_q <= '0;
            cnt_fill_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            cnt_wr_q   <= '0;
            cnt_rd_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            cnt_fill_q <= cnt_fill_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            cnt_wr_q   <= cnt_wr_d;
            cnt_rd_q   <= cnt_rd_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; heads are read combinationally, so entries live in flops.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        // Per-entry storage register, cleared on reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                tag_mem_q[gi] <= '0;
                cnt_mem_q[gi] <= '0;
            end else begin
                tag_mem_q[gi] <= tag_mem_d[gi];
                cnt_mem_q[gi] <= cnt_mem_d[gi];
            end
        end
    end

`ifdef BCH_SCHED_STATS_EN
    logic [15:0] stat_cw_q, stat_cw_d;
    logic [15:0] stat_err_cw_q, stat_err_cw_d;

    // Saturating completion counters, advanced on each tracked pop.
    always_comb begin
        stat_cw_d     = stat_cw_q;
        stat_err_cw_d = stat_err_cw_q;
        if (pop_ok && (stat_cw_q != 16'hFFFF)) begin
            stat_cw_d = stat_cw_q + 16'd1;
        end
        if (pop_ok && (out_err_count != '0) && (stat_err_cw_q != 16'hFFFF)) begin
            stat_err_cw_d = stat_err_cw_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cw_q     <= '0;
            stat_err_cw_q <= '0;
        end else begin
            stat_cw_q     <= stat_cw_d;
            stat_err_cw_q <= stat_err_cw_d;
        end
    end

    assign stat_cw     = stat_cw_q;
    assign stat_err_cw = stat_err_cw_q;
`else
    assign stat_cw     = 16'd0;
    assign stat_err_cw = 16'd0;
`endif

endmodule

// File: tb/tb_bch_decode_sched.sv
// Randomized bench for bch_decode_sched. The bench plays the syndrome unit,
// key solver and locator, and keeps a queue-based reference of codewords in
// flight (tags and solver counts) plus the flush mode and sticky error flag.
module tb_bch_decode_sched;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int ERR_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid, in_first;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready;
    logic             syn_start, syn_ce, syn_ready, syn_done;
    logic             key_start, key_ready, key_done, key_ack;
    logic [ERR_W-1:0] err_count;
    logic             loc_start, loc_ready, loc_valid, loc_first, loc_last;
    logic [TAG_W-1:0] out_tag;
    logic [ERR_W-1:0] out_err_count;
    logic             out_valid;
    logic             flush, flush_done, overflow;
    logic [15:0]      stat_cw, stat_err_cw;

    bch_decode_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_first(in_first), .in_tag(in_tag), .in_ready(in_ready),
        .syn_start(syn_start), .syn_ce(syn_ce), .syn_ready(syn_ready), .syn_done(syn_done),
        .key_start(key_start), .key_ready(key_ready), .key_done(key_done), .key_ack(key_ack),
        .err_count(err_count),
        .loc_start(loc_start), .loc_ready(loc_ready),
        .loc_valid(loc_valid), .loc_first(loc_first), .loc_last(loc_last),
        .out_tag(out_tag), .out_err_count(out_err_count), .out_valid(out_valid),
        .flush(flush), .flush_done(flush_done), .overflow(overflow),
        .stat_cw(stat_cw), .stat_err_cw(stat_err_cw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: mode 0=accepting, 1=draining, 2=drained (one cycle).
    int tag_q[$];
    int cnt_q[$];
    int m_mode;
    bit m_ov;
    int m_stat_cw, m_stat_err;
    int flush_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        tag_q.delete();
        cnt_q.delete();
        m_mode     = 0;
        m_ov       = 1'b0;
        m_stat_cw  = 0;
        m_stat_err = 0;
    endtask

    task automatic set_idle();
        in_valid = 0; in_first = 0; in_tag = '0;
        syn_ready = 0; syn_done = 0; key_ready = 0; key_done = 0; err_count = '0;
        loc_ready = 0; loc_valid = 0; loc_first = 0; loc_last = 0; flush = 0;
    endtask

    // Random sub-block behaviour that stays protocol-legal: the solver only
    // finishes codewords that entered, the locator only emits solved ones.
    task automatic set_random();
        in_valid  = 1'($urandom_range(0, 1));
        in_first  = ($urandom_range(0, 3) != 0);
        in_tag    = TAG_W'($urandom);
        syn_ready = ($urandom_range(0, 3) != 0);
        syn_done  = 1'($urandom_range(0, 1));
        key_ready = 1'($urandom_range(0, 1));
        key_done  = (cnt_q.size() < tag_q.size()) && ($urandom_range(0, 1) != 0);
        err_count = ($urandom_range(0, 1) != 0) ? ERR_W'(0) : ERR_W'($urandom);
        loc_ready = 1'($urandom_range(0, 1));
        loc_valid = (cnt_q.size() > 0) && ($urandom_range(0, 1) != 0);
        loc_first = 1'($urandom_range(0, 1));
        loc_last  = loc_valid && ($urandom_range(0, 2) == 0);
        flush     = (m_mode == 0) && ($urandom_range(0, 80) == 0);
    endtask

    // Check this cycle's outputs against the reference, advance the
    // reference as the clock edge would, then move to the next negedge.
    task automatic cycle();
        bit e_ready, e_ce, e_ss, e_ks, e_ls, e_pop, e_empty;
        int pre_cnt;
        #1;
        if (reset) begin
            model_clear();
        end else begin
            e_empty = (tag_q.size() == 0);
            e_ready = (m_mode == 0) && (tag_q.size() < DEPTH);
            e_ce    = !syn_done || key_ready;
            e_ss    = in_valid && in_first && syn_ready && e_ce && e_ready;
            e_ks    = syn_done && key_ready;
            e_ls    = key_done && loc_ready;
            e_pop   = loc_valid && loc_last;

            chk("in_ready",   32'(in_ready),   32'(e_ready));
            chk("syn_ce",     32'(syn_ce),     32'(e_ce));
            chk("syn_start",  32'(syn_start),  32'(e_ss));
            chk("key_start",  32'(key_start),  32'(e_ks));
            chk("key_ack",    32'(key_ack),    32'(e_ls));
            chk("loc_start",  32'(loc_start),  32'(e_ls));
            chk("out_valid",  32'(out_valid),  32'(loc_valid && !e_empty));
            chk("flush_done", 32'(flush_done), 32'(m_mode == 2));
            chk("overflow",   32'(overflow),   32'(m_ov));
`ifdef BCH_SCHED_STATS_EN
            chk("stat_cw",     32'(stat_cw),     32'(m_stat_cw));
            chk("stat_err_cw", 32'(stat_err_cw), 32'(m_stat_err));
`else
            chk("stat_cw",     32'(stat_cw),     32'd0);
            chk("stat_err_cw", 32'(stat_err_cw), 32'd0);
`endif
            if (!e_empty && loc_valid) chk("out_tag", 32'(out_tag), 32'(tag_q[0]));
            if (cnt_q.size() > 0 && loc_valid) chk("out_err_count", 32'(out_err_count), 32'(cnt_q[0]));
            if (m_mode == 2) flush_seen++;

            if (loc_valid && e_empty) m_ov = 1'b1;
            pre_cnt = cnt_q.size();
            if (e_ls && pre_cnt >= DEPTH) m_ov = 1'b1;

            if (m_mode == 0 && flush) m_mode = 1;
            else if (m_mode == 1 && e_empty) m_mode = 2;
            else if (m_mode == 2) m_mode = 0;

            if (e_pop && !e_empty) begin
                if (m_stat_cw < 16'hFFFF) m_stat_cw++;
                if (cnt_q.size() > 0 && cnt_q[0] != 0 && m_stat_err < 16'hFFFF) m_stat_err++;
                void'(tag_q.pop_front());
                if (cnt_q.size() > 0) void'(cnt_q.pop_front());
            end
            if (e_ls && pre_cnt < DEPTH) cnt_q.push_back(int'(err_count));
            if (e_ss) tag_q.push_back(int'(in_tag));
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        flush_seen = 0;
        model_clear();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;

        // Free-running random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            set_random();
            cycle();
        end

        // Reset in the middle of traffic clears everything on the next edge.
        set_random();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            set_random();
            cycle();
        end

        // Locator output with nothing tracked sets a sticky overflow.
        set_idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        loc_valid = 1'b1;
        loc_last  = 1'b1;
        cycle();
        set_idle();
        for (int i = 0; i < 5; i++) cycle();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("overflow_cleared", 32'(overflow), 32'd0);

        chk("flush_exercised", 32'(flush_seen > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
